// File: rtl/pr_contrib_scheduler.sv
// ---------------------------------------------------------------------------
// pr_contrib_scheduler
//
// Walks a PageRank node table once per start request. For every node it
// reads rank and out-degree, computes contribution = rank / out_deg and
// writes it to the contribution buffer.
//
// Degrees 0 and 1 skip the shared divider. A degree-0 (dangling) node writes
// 0 and is counted. A degree-1 node writes its rank unchanged.
// A division that produces no result within DIV_TIMEOUT wait cycles is
// abandoned. It writes 0 and raises the sticky err flag.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   start, num_nodes           pass request and node count (taken only in IDLE)
//   busy, done                 pass in progress / one-cycle completion pulse
//   err, dangling_cnt          per-pass status, held until the next start
//   rd_en, rd_addr             node memory read; rd_rank/rd_deg valid next cycle
//   div_start, div_dividend,
//   div_divisor                divider launch and operands (held while in flight)
//   div_done, div_quotient     divider result
//   wr_en, wr_addr, wr_data    contribution buffer write
// ---------------------------------------------------------------------------
module pr_contrib_scheduler #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_nodes,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] dangling_cnt,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_rank,
    input  logic [DATA_W-1:0] rd_deg,
    output logic              div_start,
    output logic [DATA_W-1:0] div_dividend,
    output logic [DATA_W-1:0] div_divisor,
    input  logic              div_done,
    input  logic [DATA_W-1:0] div_quotient,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int TMO_W = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT_RD,
        S_DIV_ISSUE,
        S_DIV_WAIT,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0]  num_q, num_d;
    logic               err_q, err_d;
    logic [ADDR_W-1:0]  dangling_q, dangling_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [DATA_W-1:0]  dividend_q, dividend_d;
    logic [DATA_W-1:0]  divisor_q, divisor_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    // NOTE: every register is given its own value first, so any path through
    // the case below that does not assign it keeps the old value instead of
    // inferring a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        num_d      = num_q;
        err_d      = err_q;
        dangling_d = dangling_q;
        wr_data_d  = wr_data_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        tmo_d      = tmo_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d      = num_nodes;
                    err_d      = 1'b0;
                    dangling_d = '0;
                    idx_d      = '0;
                    state_d    = (num_nodes == '0) ? S_FINISH : S_READ;
                end
            end

            S_READ: state_d = S_WAIT_RD;

            S_WAIT_RD: begin
                if (rd_deg == '0) begin
                    wr_data_d = '0;
                    if (dangling_q != {ADDR_W{1'b1}})
                        dangling_d = dangling_q + ADDR_W'(1);
                    state_d = S_WRITE;
                end else if (rd_deg == DATA_W'(1)) begin
                    wr_data_d = rd_rank;
                    state_d   = S_WRITE;
                end else begin
                    // Operands change only here, so they stay stable for the
                    // whole time the divider is working on them.
                    dividend_d = rd_rank;
                    divisor_d  = rd_deg;
                    state_d    = S_DIV_ISSUE;
                end
            end

            S_DIV_ISSUE: begin
                tmo_d   = '0;
                state_d = S_DIV_WAIT;
            end

            S_DIV_WAIT: begin
                // A result arriving on the last allowed cycle still wins
                // over the timeout.
                if (div_done) begin
                    wr_data_d = div_quotient;
                    state_d   = S_WRITE;
                end else if (tmo_q == TMO_W'(DIV_TIMEOUT - 1)) begin
                    err_d     = 1'b1;
                    wr_data_d = '0;
                    state_d   = S_WRITE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_WRITE: begin
                // The last-index compare ends the pass before idx could wrap.
                if (idx_q == num_q - ADDR_W'(1)) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = S_READ;
                end
            end

            S_FINISH: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            num_q      <= '0;
            err_q      <= 1'b0;
            dangling_q <= '0;
            wr_data_q  <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            num_q      <= num_d;
            err_q      <= err_d;
            dangling_q <= dangling_d;
            wr_data_q  <= wr_data_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            tmo_q      <= tmo_d;
        end
    end

    // Strobes decode straight from the state register. An asynchronous reset
    // therefore forces them low in the same cycle.
    assign busy         = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done         = (state_q == S_FINISH);
    assign err          = err_q;
    assign dangling_cnt = dangling_q;
    assign rd_en        = (state_q == S_READ);
    assign rd_addr      = idx_q;
    assign div_start    = (state_q == S_DIV_ISSUE);
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;
    assign wr_en        = (state_q == S_WRITE);
    assign wr_addr      = idx_q;
    assign wr_data      = wr_data_q;

endmodule

// File: tb/tb_pr_contrib_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pr_contrib_scheduler
//
// Bench for pr_contrib_scheduler. It provides a node memory, a divider with a
// per-node latency, and a monitor on the DUT outputs.
// For each pass it builds the expected write list, status and cycle count
// straight from the node table.
// ---------------------------------------------------------------------------
module tb_pr_contrib_scheduler;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 4;
    localparam int DIV_TIMEOUT = 8;
    localparam int NMAX        = 1 << ADDR_W;
    localparam int BUDGET      = 4000;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] num_nodes;
    logic              busy, done, err;
    logic [ADDR_W-1:0] dangling_cnt;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_rank = '0;
    logic [DATA_W-1:0] rd_deg = '0;
    logic              div_start;
    logic [DATA_W-1:0] div_dividend, div_divisor;
    logic              div_done = 1'b0;
    logic [DATA_W-1:0] div_quotient = '0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    always #5 clk = ~clk;

    pr_contrib_scheduler #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIV_TIMEOUT(DIV_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_nodes(num_nodes),
        .busy(busy), .done(done), .err(err), .dangling_cnt(dangling_cnt),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_rank(rd_rank), .rd_deg(rd_deg),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Node table. A latency of 0 means the divider never answers for that node.
    logic [DATA_W-1:0] rank_mem [NMAX];
    logic [DATA_W-1:0] deg_mem  [NMAX];
    int                lat_mem  [NMAX];
    int                cur_node = 0;

    always @(posedge clk) begin
        if (rd_en) begin
            rd_rank  <= rank_mem[rd_addr];
            rd_deg   <= deg_mem[rd_addr];
            cur_node <= int'(rd_addr);
        end
    end

    // Divider: div_done rises on the k-th cycle after the launch cycle.
    int rem = 0;
    always @(posedge clk) begin
        int k;
        div_done <= 1'b0;
        if (!reset) begin
            rem <= 0;
        end else if (div_start) begin
            k = lat_mem[cur_node];
            div_quotient <= (div_divisor == '0) ? '0 : div_dividend / div_divisor;
            if (k == 1) div_done <= 1'b1;
            rem <= (k > 1) ? k - 1 : 0;
        end else if (rem > 0) begin
            rem <= rem - 1;
            if (rem == 1) div_done <= 1'b1;
        end
    end

    // Monitor, sampling on the falling edge.
    typedef struct {
        int                addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               wr_q[$];
    int                rd_q[$];
    int                n_div_start = 0;
    int                n_done      = 0;
    int                n_busy      = 0;
    int                cyc_cnt     = 0;
    int                done_at     = 0;
    logic [DATA_W-1:0] op_a = '0, op_b = '0;

    always @(posedge clk) cyc_cnt++;

    always @(negedge clk) begin
        if (wr_en) wr_q.push_back('{int'(wr_addr), wr_data});
        if (rd_en) rd_q.push_back(int'(rd_addr));
        if (div_start) begin
            n_div_start++;
            op_a = div_dividend;
            op_b = div_divisor;
        end
        if (div_done && reset) begin
            check("op_hold_a", div_dividend, op_a);
            check("op_hold_b", div_divisor, op_b);
        end
        if (done) begin
            if (n_done == 0) done_at = cyc_cnt;
            n_done++;
        end
        if (busy) n_busy++;
    end

    task automatic clear_mon();
        wr_q.delete();
        rd_q.delete();
        n_div_start = 0;
        n_done      = 0;
        n_busy      = 0;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_busy"},      busy, 0);
        check({pfx, "_done"},      done, 0);
        check({pfx, "_err"},       err, 0);
        check({pfx, "_dangling"},  dangling_cnt, 0);
        check({pfx, "_rd_en"},     rd_en, 0);
        check({pfx, "_rd_addr"},   rd_addr, 0);
        check({pfx, "_div_start"}, div_start, 0);
        check({pfx, "_dividend"},  div_dividend, 0);
        check({pfx, "_divisor"},   div_divisor, 0);
        check({pfx, "_wr_en"},     wr_en, 0);
        check({pfx, "_wr_addr"},   wr_addr, 0);
        check({pfx, "_wr_data"},   wr_data, 0);
    endtask

    // Runs one pass over n nodes and checks it against the table.
    // When poke > 0, a start with num_nodes=2 is also pulsed that many
    // cycles into the pass.
    task automatic run_pass(input string tag, input int n, input int poke);
        logic [DATA_W-1:0] exp_q[$];
        int e_err = 0, e_dang = 0, e_div = 0, e_cyc = 0;
        int waited = 0;
        int start_cyc;

        for (int i = 0; i < n; i++) begin
            if (deg_mem[i] == 0) begin
                exp_q.push_back('0);
                e_dang++;
                e_cyc += 3;
            end else if (deg_mem[i] == 1) begin
                exp_q.push_back(rank_mem[i]);
                e_cyc += 3;
            end else begin
                e_div++;
                if (lat_mem[i] == 0 || lat_mem[i] > DIV_TIMEOUT) begin
                    exp_q.push_back('0);
                    e_err = 1;
                    e_cyc += 4 + DIV_TIMEOUT;
                end else begin
                    exp_q.push_back(rank_mem[i] / deg_mem[i]);
                    e_cyc += 4 + lat_mem[i];
                end
            end
        end

        repeat (2) @(negedge clk);
        clear_mon();
        start_cyc = cyc_cnt;
        num_nodes = ADDR_W'(n);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        num_nodes = ADDR_W'($urandom);
        while (n_done == 0 && waited < BUDGET) begin
            start = (poke > 0 && waited == poke);
            if (start) num_nodes = ADDR_W'(2);
            @(negedge clk);
            waited++;
        end
        start = 1'b0;
        repeat (4) @(negedge clk);

        check({tag, "_done_seen"}, (n_done > 0), 1);
        check({tag, "_done_once"}, n_done, 1);
        check({tag, "_latency"},   done_at - start_cyc, e_cyc + 1);
        check({tag, "_busy_cyc"},  n_busy, e_cyc);
        check({tag, "_div_cnt"},   n_div_start, e_div);
        check({tag, "_err"},       err, e_err);
        check({tag, "_dangling"},  dangling_cnt, e_dang);
        check({tag, "_busy_end"},  busy, 0);
        check({tag, "_n_rd"},      rd_q.size(), n);
        check({tag, "_n_wr"},      wr_q.size(), n);
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            check({tag, "_wr_addr"}, wr_q[i].addr, i);
            check({tag, "_wr_data"}, wr_q[i].data, exp_q[i]);
        end
        for (int i = 0; i < n && i < rd_q.size(); i++)
            check({tag, "_rd_addr"}, rd_q[i], i);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            int r;
            r           = $urandom_range(0, 9);
            rank_mem[i] = $urandom;
            if (r == 0)      deg_mem[i] = 0;
            else if (r == 1) deg_mem[i] = 1;
            else if (r < 8)  deg_mem[i] = $urandom_range(2, 20);
            else             deg_mem[i] = $urandom | 32'd2;
            lat_mem[i] = $urandom_range(0, 10);
        end
    endtask

    initial begin
        int waited;

        reset     = 1'b0;
        start     = 1'b0;
        num_nodes = '0;
        for (int i = 0; i < NMAX; i++) begin
            rank_mem[i] = '0;
            deg_mem[i]  = '0;
            lat_mem[i]  = 1;
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;

        // Three nodes, divider latency 3.
        rank_mem[0] = 4; deg_mem[0] = 2; lat_mem[0] = 3;
        rank_mem[1] = 4; deg_mem[1] = 1; lat_mem[1] = 3;
        rank_mem[2] = 6; deg_mem[2] = 4; lat_mem[2] = 3;
        run_pass("basic", 3, 0);

        // A single dangling node.
        rank_mem[0] = 9; deg_mem[0] = 0;
        run_pass("dangling", 1, 0);

        // Hung divider on node 0; the pass carries on and err stays set.
        rank_mem[0] = 7;  deg_mem[0] = 3; lat_mem[0] = 0;
        rank_mem[1] = 10; deg_mem[1] = 2; lat_mem[1] = 2;
        run_pass("timeout", 2, 0);
        repeat (5) @(negedge clk);
        check("timeout_err_sticky", err, 1);

        // A divider result on the last allowed wait cycle is still used.
        rank_mem[0] = 100; deg_mem[0] = 7; lat_mem[0] = DIV_TIMEOUT;
        run_pass("edge_lat", 1, 0);

        // Empty pass.
        run_pass("empty", 0, 0);

        // A start pulse while busy must be ignored.
        fill_random(5);
        run_pass("restart_ignored", 5, 6);

        // Largest node count: every index except the all-ones one.
        fill_random(NMAX - 1);
        run_pass("full", NMAX - 1, 0);

        // Reset while node 1 is waiting on the divider.
        rank_mem[0] = 30; deg_mem[0] = 3; lat_mem[0] = 2;
        rank_mem[1] = 50; deg_mem[1] = 5; lat_mem[1] = 0;
        rank_mem[2] = 8;  deg_mem[2] = 2; lat_mem[2] = 2;
        @(negedge clk);
        clear_mon();
        num_nodes = ADDR_W'(3);
        start     = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        waited = 0;
        while (n_div_start < 2 && waited < BUDGET) begin
            @(negedge clk);
            waited++;
        end
        check("rst_mid_reached", (n_div_start >= 2), 1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_all_zero("rst_mid");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_mid_wr_cnt", wr_q.size(), 1);
        check("rst_mid_no_done", n_done, 0);
        check("rst_mid_idle", busy, 0);
        lat_mem[1] = 4;
        run_pass("after_reset", 3, 0);

        // Random passes.
        for (int p = 0; p < 25; p++) begin
            int n;
            n = $urandom_range(1, NMAX - 1);
            fill_random(n);
            run_pass("random", n, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
